t05_huff_decoder: RTL

T05_HUFF_DECODER -- requirements
Module: t05_huff_decoder

---
 rtl/t05_huff_decoder.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/t05_huff_decoder.sv
// Huffman stream decoder. Reads a 32-bit character count (MSB first) from a
// bit stream, then walks a node table once per character, following the code
// bits (0 = left, 1 = right) from root node 0 down to a leaf and emitting the
// leaf character as a one-cycle strobe.
//
// Optional feature macro: T05_HUFF_DECODER_EOF_EN
//   When defined, one extra character 8'h1A is emitted after the last decoded
//   character (or straight after a zero-count header) before DONE.
//
// Ports:
//   clk, nrst            clock (rising edge), asynchronous active-low reset
//   en_state             block advances only when en_state == 4'd6
//   fin_state            high while decode complete (DONE)
//   bitIn/bitValid       encoded bit stream input
//   bitReady             a bit is accepted this cycle when bitValid is high
//   nodeAddr/nodeReq     node table read request, held until nodeValid
//   nodeData/nodeValid   node word response
//   charOut/charValid    decoded character and one-cycle strobe
//   totChar              character count taken from the header
//   err                  malformed tree detected (sticky until reset)
module t05_huff_decoder #(
  parameter int unsigned MAX_DEPTH = 127
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [3:0]  en_state,
  output logic        fin_state,
  input  logic        bitIn,
  input  logic        bitValid,
  output logic        bitReady,
  output logic [6:0]  nodeAddr,
  output logic        nodeReq,
  input  logic [15:0] nodeData,
  input  logic        nodeValid,
  output logic [7:0]  charOut,
  output logic        charValid,
  output logic [31:0] totChar,
  output logic        err
);

  typedef enum logic [2:0] {
    StHeader, StFetch, StWaitNode, StNeedBit, StEmit, StDone, StError
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] tot_q, tot_d;
  logic [31:0] rem_q, rem_d;
  logic [5:0]  hdr_cnt_q, hdr_cnt_d;
  logic [6:0]  node_q, node_d;
  logic [7:0]  depth_q, depth_d;
  logic [13:0] kids_q, kids_d;  // child indices of the internal node being walked
  logic [7:0]  char_q, char_d;
`ifdef T05_HUFF_DECODER_EOF_EN
  localparam logic [7:0] EofChar = 8'h1A;
  logic        eof_q, eof_d;    // current EMIT is the trailing EOF character
`endif

  logic        active;
  logic [31:0] tot_shift;
  logic [6:0]  child;
  logic        depth_hit;
  logic        unused_bit14;

  // Reset gates the handshake outputs so they read as idle while nrst is low.
  assign active    = nrst && (en_state == 4'd6);
  assign tot_shift = {tot_q[30:0], bitIn};
  assign child     = bitIn ? kids_q[6:0] : kids_q[13:7];
  assign depth_hit = (32'(depth_q) + 32'd1) >= MAX_DEPTH;
  assign unused_bit14 = nodeData[14];

  always_comb begin
    state_d   = state_q;
    tot_d     = tot_q;
    rem_d     = rem_q;
    hdr_cnt_d = hdr_cnt_q;
    node_d    = node_q;
    depth_d   = depth_q;
    kids_d    = kids_q;
    char_d    = char_q;
`ifdef T05_HUFF_DECODER_EOF_EN
    eof_d     = eof_q;
`endif
    bitReady  = 1'b0;
    nodeReq   = 1'b0;
    charValid = 1'b0;

    if (active) begin
      unique case (state_q)
        StHeader: begin
          bitReady = 1'b1;
          if (bitValid) begin
            tot_d     = tot_shift;
            hdr_cnt_d = hdr_cnt_q + 6'd1;
            if (hdr_cnt_q == 6'd31) begin
              rem_d   = tot_shift;
              node_d  = '0;
              depth_d = '0;
              if (tot_shift == 32'd0) begin
`ifdef T05_HUFF_DECODER_EOF_EN
                eof_d   = 1'b1;
                char_d  = EofChar;
                state_d = StEmit;
`else
                state_d = StDone;
`endif
              end else begin
                state_d = StFetch;
              end
            end
          end
        end
        StFetch: begin
          nodeReq = 1'b1;
          state_d = StWaitNode;
        end
        StWaitNode: begin
          nodeReq = 1'b1;
          if (nodeValid) begin
            if (nodeData[15]) begin
              char_d  = nodeData[7:0];
              state_d = StEmit;
            end else begin
              kids_d  = nodeData[13:0];
              state_d = StNeedBit;
            end
          end
        end
        StNeedBit: begin
          bitReady = 1'b1;
          if (bitValid) begin
            node_d  = child;
            depth_d = depth_q + 8'd1;
            // Child 0 would point back at the root: treat as a broken tree.
            if ((child == 7'd0) || depth_hit) state_d = StError;
            else                              state_d = StFetch;
          end
        end
        StEmit: begin
          charValid = 1'b1;
          node_d    = '0;
          depth_d   = '0;
          if (rem_q != 32'd0) rem_d = rem_q - 32'd1;
`ifdef T05_HUFF_DECODER_EOF_EN
          if (eof_q) begin
            eof_d   = 1'b0;
            state_d = StDone;
          end else if (rem_q <= 32'd1) begin
            eof_d   = 1'b1;
            char_d  = EofChar;
            state_d = StEmit;
          end else begin
            state_d = StFetch;
          end
`else
          if (rem_q <= 32'd1) state_d = StDone;
          else                state_d = StFetch;
`endif
        end
        StDone, StError: ;
        default: state_d = StError;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= StHeader;
      tot_q     <= '0;
      rem_q     <= '0;
      hdr_cnt_q <= '0;
      node_q    <= '0;
      depth_q   <= '0;
      kids_q    <= '0;
      char_q    <= '0;
`ifdef T05_HUFF_DECODER_EOF_EN
      eof_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      tot_q     <= tot_d;
      rem_q     <= rem_d;
      hdr_cnt_q <= hdr_cnt_d;
      node_q    <= node_d;
      depth_q   <= depth_d;
      kids_q    <= kids_d;
      char_q    <= char_d;
`ifdef T05_HUFF_DECODER_EOF_EN
      eof_q     <= eof_d;
`endif
    end
  end

  assign nodeAddr  = node_q;
  assign charOut   = char_q;
  assign totChar   = tot_q;
  assign fin_state = (state_q == StDone);
  assign err       = (state_q == StError);

endmodule
